// File: rtl/draw_pkg.sv
// Shared types and default colours for the border effect block.
// Holds the flash FSM state encoding and the 3-bit colour type.
package draw_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      FLASH_ON  = 2'd1,
      FLASH_OFF = 2'd2
   } state_t;

   typedef logic [2:0] rgb_t;

   localparam rgb_t DEF_COLOR       = 3'b111;
   localparam rgb_t DEF_FLASH_COLOR = 3'b100;
   localparam rgb_t DEF_CHASE_COLOR = 3'b010;

endpackage

// File: rtl/border_hit.sv
// Combinational tile compare: flags pixels lying in the outermost ring of
// (1 << TILE_SHIFT)-pixel tiles around the visible area.
module border_hit #(
   parameter int BIT        = 10,
   parameter int TILE_SHIFT = 3,
   parameter int H_LAST     = 639,
   parameter int V_LAST     = 479
) (
   input  logic [BIT-1:0] i_xPos,
   input  logic [BIT-1:0] i_yPos,
   output logic           o_hit
);

   localparam logic [BIT-1:0] LP_H_TILE = BIT'(H_LAST >> TILE_SHIFT);
   localparam logic [BIT-1:0] LP_V_TILE = BIT'(V_LAST >> TILE_SHIFT);

   logic [BIT-1:0] w_xTile;
   logic [BIT-1:0] w_yTile;

   assign w_xTile = i_xPos >> TILE_SHIFT;
   assign w_yTile = i_yPos >> TILE_SHIFT;

   assign o_hit = (w_xTile == '0) || (w_xTile == LP_H_TILE) ||
                  (w_yTile == '0) || (w_yTile == LP_V_TILE);

endmodule

// File: rtl/draw_border_fx.sv
// Screen border renderer with a frame-timed flash sequence.
// Optional marquee highlight is compiled in with `define BORDER_CHASE_EN.
module draw_border_fx
   import draw_pkg::*;
#(
   parameter int   BIT           = 10,
   parameter int   TILE_SHIFT    = 3,
   parameter int   H_LAST        = 639,
   parameter int   V_LAST        = 479,
   parameter rgb_t COLOR         = DEF_COLOR,
   parameter rgb_t FLASH_COLOR   = DEF_FLASH_COLOR,
   parameter int   FLASH_PERIOD  = 8,
   parameter int   FLASH_TOGGLES = 6,
   parameter rgb_t CHASE_COLOR   = DEF_CHASE_COLOR
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [BIT-1:0] x_pos,
   input  logic [BIT-1:0] y_pos,
   input  logic           frame_tick,
   input  logic           flash_start,
   output logic           border_active,
   output logic [2:0]     rgb,
   output logic           flashing
);

   localparam logic [7:0] LP_PERIOD_LAST = 8'(FLASH_PERIOD - 1);
   localparam logic [7:0] LP_TOGGLE_LAST = 8'(FLASH_TOGGLES - 1);

   state_t     r_state;
   logic [7:0] r_frameCnt;
   logic [7:0] r_toggleCnt;
   logic       w_hit;
   rgb_t       w_idleRgb;

   border_hit #(
      .BIT        (BIT),
      .TILE_SHIFT (TILE_SHIFT),
      .H_LAST     (H_LAST),
      .V_LAST     (V_LAST)
   ) u_borderHit (
      .i_xPos (x_pos),
      .i_yPos (y_pos),
      .o_hit  (w_hit)
   );

`ifdef BORDER_CHASE_EN
   logic [1:0] r_chasePhase;
   logic [1:0] w_tileSum;

   // Tile whose diagonal index matches the marquee phase gets the highlight.
   assign w_tileSum = 2'((x_pos >> TILE_SHIFT) + (y_pos >> TILE_SHIFT));
   assign w_idleRgb = (w_tileSum == r_chasePhase) ? CHASE_COLOR : COLOR;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_chasePhase <= 2'd0;
      end else if (frame_tick) begin
         r_chasePhase <= r_chasePhase + 2'd1;
      end
   end
`else
   assign w_idleRgb = COLOR;
`endif

   // Outputs use the state held during this pixel; flashing tracks the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= IDLE;
         r_frameCnt    <= 8'd0;
         r_toggleCnt   <= 8'd0;
         border_active <= 1'b0;
         rgb           <= 3'b000;
         flashing      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               border_active <= w_hit;
               rgb           <= w_hit ? w_idleRgb : 3'b000;
            end
            FLASH_ON: begin
               border_active <= w_hit;
               rgb           <= w_hit ? FLASH_COLOR : 3'b000;
            end
            default: begin
               border_active <= 1'b0;
               rgb           <= 3'b000;
            end
         endcase

         if (flash_start) begin
            r_state     <= FLASH_ON;
            r_frameCnt  <= 8'd0;
            r_toggleCnt <= 8'd0;
            flashing    <= 1'b1;
         end else if (frame_tick && (r_state != IDLE)) begin
            if (r_frameCnt == LP_PERIOD_LAST) begin
               r_frameCnt <= 8'd0;
               if (r_toggleCnt == LP_TOGGLE_LAST) begin
                  r_state     <= IDLE;
                  r_toggleCnt <= 8'd0;
                  flashing    <= 1'b0;
               end else begin
                  r_toggleCnt <= r_toggleCnt + 8'd1;
                  r_state     <= (r_state == FLASH_ON) ? FLASH_OFF : FLASH_ON;
               end
            end else begin
               r_frameCnt <= r_frameCnt + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_draw_border_fx.sv
// Directed bench for draw_border_fx: tile compare vectors plus flash,
// restart, reset-abort and (with BORDER_CHASE_EN) marquee sequences.
module tb_draw_border_fx;

   logic       clk;
   logic       rst;
   logic [9:0] x_pos;
   logic [9:0] y_pos;
   logic       frame_tick;
   logic       flash_start;
   logic       border_active;
   logic [2:0] rgb;
   logic       flashing;

   int compareCount;
   int mismatchCount;
   int tbPhase;

   typedef struct {
      logic [9:0] x;
      logic [9:0] y;
      logic       expActive;
   } vector_t;

   vector_t vectors[12];

   draw_border_fx dut (
      .clk           (clk),
      .rst           (rst),
      .x_pos         (x_pos),
      .y_pos         (y_pos),
      .frame_tick    (frame_tick),
      .flash_start   (flash_start),
      .border_active (border_active),
      .rgb           (rgb),
      .flashing      (flashing)
   );

   // 10 ns pixel clock; inputs change and outputs are sampled on the falling edge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Idle colour for a lit pixel, including the marquee highlight when built in.
   function automatic logic [2:0] idleRgb(input logic [9:0] x, input logic [9:0] y,
                                          input logic active);
      logic [1:0] sum;
      if (!active) return 3'b000;
      sum = 2'((x >> 3) + (y >> 3));
`ifdef BORDER_CHASE_EN
      if (sum == 2'(tbPhase)) return 3'b010;
`endif
      if (sum == 2'd3) return 3'b111;
      return 3'b111;
   endfunction

   task automatic compareBit(input string name, input logic act, input logic exp);
      compareCount++;
      if (act !== exp) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string name, input logic expActive,
                              input logic [2:0] expRgb, input logic expFlash);
      compareBit({name, ".active"}, border_active, expActive);
      compareCount++;
      if (rgb !== expRgb) begin
         mismatchCount++;
         $display("[TB] FAIL %s.rgb: got %b expected %b", name, rgb, expRgb);
      end
      compareBit({name, ".flashing"}, flashing, expFlash);
   endtask

   // Set pixel, then wait one cycle so the registered output reflects it.
   task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y);
      @(negedge clk);
      x_pos = x;
      y_pos = y;
      @(negedge clk);
   endtask

   // One frame_tick pulse, then one extra cycle so outputs show the new state.
   task automatic pulseTick();
      @(negedge clk);
      frame_tick = 1'b1;
      tbPhase    = (tbPhase + 1) % 4;
      @(negedge clk);
      frame_tick = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulseStart(input logic withTick);
      @(negedge clk);
      flash_start = 1'b1;
      frame_tick  = withTick;
      if (withTick) tbPhase = (tbPhase + 1) % 4;
      @(negedge clk);
      flash_start = 1'b0;
      frame_tick  = 1'b0;
      @(negedge clk);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) pulseTick();
   endtask

   initial begin
      compareCount  = 0;
      mismatchCount = 0;
      tbPhase       = 0;
      rst           = 1'b1;
      x_pos         = 10'd0;
      y_pos         = 10'd100;
      frame_tick    = 1'b0;
      flash_start   = 1'b0;

      vectors[0]  = '{10'd0,   10'd100, 1'b1};
      vectors[1]  = '{10'd8,   10'd8,   1'b0};
      vectors[2]  = '{10'd632, 10'd240, 1'b1};
      vectors[3]  = '{10'd320, 10'd472, 1'b1};
      vectors[4]  = '{10'd631, 10'd471, 1'b0};
      vectors[5]  = '{10'd7,   10'd7,   1'b1};
      vectors[6]  = '{10'd639, 10'd479, 1'b1};
      vectors[7]  = '{10'd100, 10'd0,   1'b1};
      vectors[8]  = '{10'd320, 10'd240, 1'b0};
      vectors[9]  = '{10'd8,   10'd471, 1'b0};
      vectors[10] = '{10'd631, 10'd8,   1'b0};
      vectors[11] = '{10'd623, 10'd464, 1'b0};

      repeat (3) @(negedge clk);
      checkOutput("reset", 1'b0, 3'b000, 1'b0);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         applyStimulus(vectors[i].x, vectors[i].y);
         checkOutput($sformatf("vec%0d", i), vectors[i].expActive,
                     idleRgb(vectors[i].x, vectors[i].y, vectors[i].expActive), 1'b0);
      end

      // Full flash sequence on a left-edge pixel.
      applyStimulus(10'd0, 10'd100);
      pulseStart(1'b0);
      checkOutput("flashStart", 1'b1, 3'b100, 1'b1);
      ticks(7);
      checkOutput("flashOn7", 1'b1, 3'b100, 1'b1);
      ticks(1);
      checkOutput("flashOff8", 1'b0, 3'b000, 1'b1);
      ticks(7);
      checkOutput("flashOff15", 1'b0, 3'b000, 1'b1);
      ticks(1);
      checkOutput("flashOn16", 1'b1, 3'b100, 1'b1);
      ticks(31);
      checkOutput("flash47", 1'b0, 3'b000, 1'b1);
      ticks(1);
      checkOutput("flashDone", 1'b1, idleRgb(10'd0, 10'd100, 1'b1), 1'b0);
      ticks(1);
      checkOutput("idleTick", 1'b1, idleRgb(10'd0, 10'd100, 1'b1), 1'b0);

      // Restart mid-sequence with a simultaneous tick that must be ignored.
      pulseStart(1'b0);
      ticks(20);
      checkOutput("pre-restart", 1'b1, 3'b100, 1'b1);
      pulseStart(1'b1);
      checkOutput("restart", 1'b1, 3'b100, 1'b1);
      ticks(7);
      checkOutput("restartOn7", 1'b1, 3'b100, 1'b1);
      ticks(1);
      checkOutput("restartOff8", 1'b0, 3'b000, 1'b1);
      ticks(39);
      checkOutput("restart47", 1'b0, 3'b000, 1'b1);
      ticks(1);
      checkOutput("restartDone", 1'b1, idleRgb(10'd0, 10'd100, 1'b1), 1'b0);

      // Reset during FLASH_OFF aborts immediately.
      pulseStart(1'b0);
      ticks(8);
      checkOutput("preAbort", 1'b0, 3'b000, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      tbPhase = 0;
      #1;
      checkOutput("abortAsync", 1'b0, 3'b000, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("postAbort", 1'b1, idleRgb(10'd0, 10'd100, 1'b1), 1'b0);

`ifdef BORDER_CHASE_EN
      ticks(1);
      applyStimulus(10'd8, 10'd0);
      checkOutput("chaseTile10", 1'b1, 3'b010, 1'b0);
      applyStimulus(10'd0, 10'd0);
      checkOutput("chaseTile00", 1'b1, 3'b111, 1'b0);
      ticks(3);
      checkOutput("chaseWrap00", 1'b1, 3'b010, 1'b0);
      applyStimulus(10'd8, 10'd0);
      checkOutput("chaseWrap10", 1'b1, 3'b111, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
